// File: rtl/count_param_if.sv
// Counter control/data bundle for count_param: enable, mode, load value, count and carry pulse.
// The master side drives control and load data; the slave side (the counter) returns Q and rco.
interface count_param_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enable;
    logic [1:0]       modo;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             rco;

    modport master (
        output enable,
        output modo,
        output D,
        input  Q,
        input  rco
    );

    modport slave (
        input  enable,
        input  modo,
        input  D,
        output Q,
        output rco
    );
endinterface

// File: rtl/count_param.sv
// Parametrised up/down/step/load counter with a registered one-cycle ripple-carry pulse.
// Define COUNT_PARAM_SAT_EN to saturate at the count bounds instead of wrapping.
module count_param #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 3
) (
    input  logic          clk,
    input  logic          reset,
    count_param_if.slave  bus
);

    typedef enum logic [1:0] {
        ModeInc  = 2'b00,
        ModeDec  = 2'b01,
        ModeStep = 2'b10,
        ModeLoad = 2'b11
    } mode_e;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("count_param: WIDTH must be in 2..32");
    end
    if (STEP < 1 || 64'(STEP) >= (64'd1 << WIDTH)) begin : g_bad_step
        $error("count_param: STEP must be in 1..2^WIDTH-1");
    end

    localparam logic [WIDTH:0]   StepW = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] QMax  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;

    // One extra bit on each result: carry-out on increment, borrow on the subtracts.
    logic [WIDTH:0] inc_w, dec_w, step_w;
    mode_e          mode;

    assign inc_w  = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w  = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
    assign step_w = {1'b0, q_q} - StepW;
    assign mode   = mode_e'(bus.modo);

    always_comb begin
        q_d   = q_q;
        rco_d = 1'b0;
        if (bus.enable) begin
            unique case (mode)
                ModeInc: begin
                    rco_d = inc_w[WIDTH];
`ifdef COUNT_PARAM_SAT_EN
                    q_d = inc_w[WIDTH] ? QMax : inc_w[WIDTH-1:0];
`else
                    q_d = inc_w[WIDTH-1:0];
`endif
                end
                ModeDec: begin
                    rco_d = dec_w[WIDTH];
`ifdef COUNT_PARAM_SAT_EN
                    q_d = dec_w[WIDTH] ? '0 : dec_w[WIDTH-1:0];
`else
                    q_d = dec_w[WIDTH-1:0];
`endif
                end
                ModeStep: begin
                    rco_d = step_w[WIDTH];
`ifdef COUNT_PARAM_SAT_EN
                    q_d = step_w[WIDTH] ? '0 : step_w[WIDTH-1:0];
`else
                    q_d = step_w[WIDTH-1:0];
`endif
                end
                ModeLoad: begin
                    // A load always pulses rco, matching the legacy counter.
                    q_d   = bus.D;
                    rco_d = 1'b1;
                end
                default: begin
                    q_d   = q_q;
                    rco_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end

    assign bus.Q   = q_q;
    assign bus.rco = rco_q;

    a_modo_known: assert property (@(posedge clk) disable iff (reset)
        bus.enable |-> !$isunknown(bus.modo))
        else $error("count_param: modo is X/Z while enable=1");

endmodule

// File: tb/tb_count_param.sv
// Directed self-checking bench for count_param (WIDTH=4/STEP=3 and WIDTH=8/STEP=5 instances).
module tb_count_param;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    count_param_if #(.WIDTH(4)) bus4 ();
    count_param_if #(.WIDTH(8)) bus8 ();

    count_param #(.WIDTH(4), .STEP(3)) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    count_param #(.WIDTH(8), .STEP(5)) u8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] q, input logic r);
        check({tag, ".Q"}, 32'(bus4.Q), 32'(q));
        check({tag, ".rco"}, 32'(bus4.rco), 32'(r));
    endtask

    task automatic chk8(input string tag, input logic [7:0] q, input logic r);
        check({tag, ".Q"}, 32'(bus8.Q), 32'(q));
        check({tag, ".rco"}, 32'(bus8.rco), 32'(r));
    endtask

    initial begin
        logic [3:0] eq;
        logic       er;

        reset = 1'b1;
        bus4.enable = 1'b1; bus4.modo = 2'b11; bus4.D = 4'hA;
        bus8.enable = 1'b0; bus8.modo = 2'b00; bus8.D = 8'h00;
        tick();
        tick();
        chk4("reset", 4'h0, 1'b0);
        chk8("reset8", 8'h00, 1'b0);

        // Count up 17 edges from 0.
        reset = 1'b0;
        bus4.modo = 2'b00;
        for (int i = 1; i <= 17; i++) begin
            tick();
`ifdef COUNT_PARAM_SAT_EN
            eq = (i >= 16) ? 4'hF : 4'(i);
            er = (i >= 16);
`else
            eq = 4'(i % 16);
            er = (i == 16);
`endif
            chk4($sformatf("up%0d", i), eq, er);
        end

        // Load 2, then two -STEP edges.
        bus4.modo = 2'b11; bus4.D = 4'h2;
        tick();
        chk4("load2", 4'h2, 1'b1);
        bus4.modo = 2'b10;
        tick();
`ifdef COUNT_PARAM_SAT_EN
        chk4("step_wrap", 4'h0, 1'b1);
        tick();
        chk4("step_again", 4'h0, 1'b1);
`else
        chk4("step_wrap", 4'hF, 1'b1);
        tick();
        chk4("step_again", 4'hC, 1'b0);
`endif

        // Back to 0, decrement through zero, then hold.
        reset = 1'b1;
        tick();
        chk4("reset_mid", 4'h0, 1'b0);
        reset = 1'b0;
        bus4.modo = 2'b01;
        tick();
`ifdef COUNT_PARAM_SAT_EN
        eq = 4'h0;
`else
        eq = 4'hF;
`endif
        chk4("dec_wrap", eq, 1'b1);
        bus4.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4($sformatf("hold%0d", i), eq, 1'b0);
        end

        // WIDTH=8, STEP=5.
        bus8.enable = 1'b1; bus8.modo = 2'b11; bus8.D = 8'h03;
        tick();
        chk8("w8_load", 8'h03, 1'b1);
        bus8.modo = 2'b10;
        tick();
`ifdef COUNT_PARAM_SAT_EN
        chk8("w8_step_wrap", 8'h00, 1'b1);
        tick();
        chk8("w8_step_again", 8'h00, 1'b1);
`else
        chk8("w8_step_wrap", 8'hFE, 1'b1);
        tick();
        chk8("w8_step_again", 8'hF9, 1'b0);
`endif
        bus8.enable = 1'b0;

        // Reset beats a load; back-to-back loads keep rco high.
        bus4.enable = 1'b1; bus4.modo = 2'b11; bus4.D = 4'h8;
        tick();
        bus4.D = 4'h9;
        tick();
        chk4("load9", 4'h9, 1'b1);
        reset = 1'b1; bus4.D = 4'h7;
        tick();
        chk4("reset_vs_load", 4'h0, 1'b0);
        reset = 1'b0; bus4.modo = 2'b00;
        tick();
        chk4("after_reset", 4'h1, 1'b0);

        // Bound behaviour around max and below STEP.
        bus4.modo = 2'b11; bus4.D = 4'hE;
        tick();
        bus4.modo = 2'b00;
        tick();
        chk4("sat_e1", 4'hF, 1'b0);
        tick();
`ifdef COUNT_PARAM_SAT_EN
        chk4("sat_e2", 4'hF, 1'b1);
        tick();
        chk4("sat_e3", 4'hF, 1'b1);
`else
        chk4("sat_e2", 4'h0, 1'b1);
        tick();
        chk4("sat_e3", 4'h1, 1'b0);
`endif
        bus4.modo = 2'b11; bus4.D = 4'h1;
        tick();
        bus4.modo = 2'b10;
        tick();
`ifdef COUNT_PARAM_SAT_EN
        chk4("step_from1", 4'h0, 1'b1);
`else
        chk4("step_from1", 4'hE, 1'b1);
`endif

        // Plain decrement and plain step without wrap.
        bus4.modo = 2'b11; bus4.D = 4'h5;
        tick();
        bus4.modo = 2'b01;
        tick();
        chk4("dec_plain", 4'h4, 1'b0);
        bus4.modo = 2'b10;
        tick();
        chk4("step_plain", 4'h1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
